// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: XLEN, PC step, default reset PC,
// fetch FSM state encoding and an alignment helper.
package cpu_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_t;

   // Instruction addresses must be word aligned.
   function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/adder.sv
// Unsigned W-bit adder; the carry out is discarded so the sum wraps.
module adder
   import cpu_pkg::*;
#(
   parameter int W = XLEN
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/pc_fetch.sv
// Program counter and fetch-request stage: one valid/ready request per cycle,
// PC+4 sequencing, branch redirects, stalls and a sticky misaligned-target fault.
module pc_fetch
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            fetch_ready,
   output logic            fetch_valid,
   output logic [XLEN-1:0] fetch_pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            fault,
   output logic [XLEN-1:0] issue_count
);

   fetch_state_t    state_r, state_n;
   logic [XLEN-1:0] pc_r, pc_n;
   logic            valid_r, valid_n;
   logic            fault_r, fault_n;
   logic [XLEN-1:0] count_r, count_n;
   logic            accept_s, mis_s, ali_s;

   adder #(.W(XLEN)) u_pc_adder (
      .a   (pc_r),
      .b   (PC_STEP),
      .sum (pc_plus4)
   );

   assign fetch_valid = valid_r;
   assign fetch_pc    = pc_r;
   assign fault       = fault_r;
   assign issue_count = count_r;

   // Next-state and next-register logic of the fetch FSM.
   always_comb begin
      state_n  = state_r;
      pc_n     = pc_r;
      valid_n  = valid_r;
      fault_n  = fault_r;
      count_n  = count_r;
      accept_s = valid_r & fetch_ready;
      mis_s    = redirect_valid & is_misaligned(redirect_pc);
      ali_s    = redirect_valid & ~mis_s;

      case (state_r)
         ST_BOOT, ST_RUN: begin
            if (mis_s) begin
               state_n = ST_FAULT;
               pc_n    = redirect_pc;
               valid_n = 1'b0;
               fault_n = 1'b1;
            end else if (ali_s) begin
               // The redirect replaces any pending request, but a request
               // accepted this same cycle still counts as issued.
               pc_n = redirect_pc;
               if (accept_s) begin
                  count_n = count_r + 32'd1;
               end else begin
                  count_n = count_r;
               end
               if (stall) begin
                  state_n = ST_STALL;
                  valid_n = 1'b0;
               end else begin
                  state_n = ST_RUN;
                  valid_n = 1'b1;
               end
            end else if (accept_s) begin
               count_n = count_r + 32'd1;
               pc_n    = pc_plus4;
               if (stall) begin
                  state_n = ST_STALL;
                  valid_n = 1'b0;
               end else begin
                  state_n = ST_RUN;
                  valid_n = 1'b1;
               end
            end else if (state_r == ST_BOOT) begin
               if (stall) begin
                  state_n = ST_STALL;
                  valid_n = 1'b0;
               end else begin
                  state_n = ST_RUN;
                  valid_n = 1'b1;
               end
            end else begin
               // Pending request is held; a stall never withdraws it.
               state_n = ST_RUN;
               valid_n = 1'b1;
            end
         end
         ST_STALL: begin
            if (mis_s) begin
               state_n = ST_FAULT;
               pc_n    = redirect_pc;
               valid_n = 1'b0;
               fault_n = 1'b1;
            end else if (ali_s) begin
               pc_n    = redirect_pc;
               valid_n = 1'b0;
            end else if (!stall) begin
               state_n = ST_RUN;
               valid_n = 1'b1;
            end else begin
               valid_n = 1'b0;
            end
         end
         ST_FAULT: begin
            valid_n = 1'b0;
            fault_n = 1'b1;
         end
         default: begin
            state_n = ST_BOOT;
            valid_n = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_BOOT;
         pc_r    <= RESET_PC;
         valid_r <= 1'b0;
         fault_r <= 1'b0;
         count_r <= '0;
      end else begin
         state_r <= state_n;
         pc_r    <= pc_n;
         valid_r <= valid_n;
         fault_r <= fault_n;
         count_r <= count_n;
      end
   end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: a behavioural reference model pushes the
// expected outputs to a scoreboard each cycle; they are popped after the edge.
module tb_pc_fetch;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_ready;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] pc_plus4;
   logic        fault;
   logic [31:0] issue_count;

   pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_ready    (fetch_ready),
      .fetch_valid    (fetch_valid),
      .fetch_pc       (fetch_pc),
      .pc_plus4       (pc_plus4),
      .fault          (fault),
      .issue_count    (issue_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic [31:0] p4;
      logic        f;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   localparam int M_BOOT = 0, M_RUN = 1, M_STALL = 2, M_FAULT = 3;
   int          m_st  = M_BOOT;
   logic        m_v   = 1'b0;
   logic [31:0] m_pc  = 32'h0;
   logic        m_f   = 1'b0;
   logic [31:0] m_cnt = 32'h0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference behaviour written from the state descriptions.
   task automatic model(input logic r, input logic st, input logic rv,
                        input logic [31:0] rpc, input logic rdy);
      logic acc, mis, ali;
      acc = m_v & rdy;
      mis = rv & (rpc[1:0] != 2'b00);
      ali = rv & ~mis;
      if (r) begin
         m_st = M_BOOT; m_v = 1'b0; m_pc = 32'h0; m_f = 1'b0; m_cnt = 32'h0;
      end else if (m_st == M_FAULT) begin
         m_v = 1'b0;
      end else if (mis) begin
         m_st = M_FAULT; m_v = 1'b0; m_pc = rpc; m_f = 1'b1;
      end else if (m_st == M_STALL) begin
         if (ali) m_pc = rpc;
         else if (!st) begin m_st = M_RUN; m_v = 1'b1; end
      end else if (ali) begin
         if (acc) m_cnt = m_cnt + 32'd1;
         m_pc = rpc;
         m_st = st ? M_STALL : M_RUN;
         m_v  = ~st;
      end else if (acc) begin
         m_cnt = m_cnt + 32'd1;
         m_pc  = m_pc + 32'd4;
         if (st) begin m_st = M_STALL; m_v = 1'b0; end
      end else if (m_st == M_BOOT) begin
         m_st = st ? M_STALL : M_RUN;
         m_v  = ~st;
      end
   endtask

   task automatic step(input logic r, input logic st, input logic rv,
                       input logic [31:0] rpc, input logic rdy);
      exp_t e;
      rst = r; stall = st; redirect_valid = rv; redirect_pc = rpc; fetch_ready = rdy;
      model(r, st, rv, rpc, rdy);
      e.v = m_v; e.pc = m_pc; e.p4 = m_pc + 32'd4; e.f = m_f; e.cnt = m_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_val("valid", {31'd0, fetch_valid}, {31'd0, e.v});
      check_val("pc",    fetch_pc,    e.pc);
      check_val("plus4", pc_plus4,    e.p4);
      check_val("fault", {31'd0, fault}, {31'd0, e.f});
      check_val("count", issue_count, e.cnt);
   endtask

   initial begin
      logic [31:0] rnd;
      logic [31:0] rpc;
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; fetch_ready = 1'b1;

      // Reset, then sequential fetch at full throughput.
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      check_val("rst_valid", {31'd0, fetch_valid}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check_val("seq_pc0", fetch_pc, 32'h0);
      check_val("seq_v0", {31'd0, fetch_valid}, 32'd1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check_val("seq_pc4", fetch_pc, 32'h4);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check_val("seq_pc8", fetch_pc, 32'h8);

      // Backpressure with stall asserted: request at 0x8 must hold.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      check_val("bp_pc", fetch_pc, 32'h8);
      check_val("bp_cnt", issue_count, 32'd2);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check_val("bp_next", fetch_pc, 32'hC);
      check_val("seq_cnt3", issue_count, 32'd3);

      // Redirect back to 0x8 on an accept, then redirect over the pending request.
      step(1'b0, 1'b0, 1'b1, 32'h8, 1'b1);
      step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
      check_val("rd_pc", fetch_pc, 32'h100);
      check_val("rd_cnt", issue_count, 32'd4);

      // Stall on accept at 0x10, stall held, then released.
      step(1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      check_val("sa_valid", {31'd0, fetch_valid}, 32'd0);
      check_val("sa_pc", fetch_pc, 32'h14);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'h40, 1'b1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check_val("sr_pc", fetch_pc, 32'h40);
      check_val("sr_valid", {31'd0, fetch_valid}, 32'd1);

      // PC wrap at the top of the address space.
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      check_val("wrap_p4", pc_plus4, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check_val("wrap_pc", fetch_pc, 32'h0);

      // Reset while stalled.
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      check_val("rs_cnt", issue_count, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check_val("rs_boot", {31'd0, fetch_valid}, 32'd1);

      // Misaligned redirect faults; later inputs are ignored until reset.
      step(1'b0, 1'b0, 1'b1, 32'h102, 1'b1);
      check_val("mis_fault", {31'd0, fault}, 32'd1);
      check_val("mis_pc", fetch_pc, 32'h102);
      step(1'b0, 1'b0, 1'b1, 32'h200, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      check_val("mis_hold", fetch_pc, 32'h102);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      check_val("mis_rst_f", {31'd0, fault}, 32'd0);
      check_val("mis_rst_pc", fetch_pc, 32'h0);

      // Randomised traffic against the model.
      for (int i = 0; i < 120; i++) begin
         rnd = $urandom;
         rpc = {rnd[31:2], 2'b00};
         if ($urandom_range(0, 9) == 0) rpc[1:0] = 2'b10;
         step(($urandom_range(0, 14) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 5) == 0), rpc, ($urandom_range(0, 2) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and fetch-request stage of the CPU datapath. Holds the architectural PC, issues one instruction-fetch request per cycle over a valid/ready handshake, and advances the PC by 4 using the 32-bit `adder` as its incrementer. Accepts branch/jump redirects and a pipeline stall. A misaligned redirect target latches a fault. Sits directly upstream of instruction memory and decode, and feeds the PC adder.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: pipeline stall; blocks launching a new request.
- `redirect_valid` in 1: branch/jump redirect strobe, one cycle.
- `redirect_pc` in 32: redirect target address.
- `fetch_ready` in 1: instruction memory accepts the current request.
- `fetch_valid` out 1: fetch request valid.
- `fetch_pc` out 32: address of the current request, or the faulting target while in FAULT.
- `pc_plus4` out 32: combinational `fetch_pc + 4`, produced by the adder; wraps mod 2^32.
- `fault` out 1: misaligned-redirect fault, sticky until `rst`.
- `issue_count` out 32: number of accepted fetch requests; wraps.

## Operation
- States: BOOT, RUN, STALL, FAULT.
- Accept: `fetch_valid & fetch_ready` in the same cycle.
- Reset (`rst` = 1 at the edge), reset values:
  - state = BOOT
  - `fetch_pc` = RESET_PC
  - `fetch_valid` = 0
  - `fault` = 0
  - `issue_count` = 0
  - Reset overrides everything, including in FAULT and mid-stall.
- BOOT:
  - If `stall` = 0: go to RUN and set `fetch_valid` = 1.
  - If `stall` = 1: go to STALL.
  - Redirects arriving in BOOT are handled as in RUN.
- RUN (`fetch_valid` is always 1). Conditions are evaluated in priority order:
  1. Misaligned redirect (`redirect_valid` with `redirect_pc[1:0]` != 0): go to FAULT; `fetch_pc` <= `redirect_pc`; `fetch_valid` <= 0; `fault` <= 1.
  2. Aligned redirect: `fetch_pc` <= `redirect_pc`. This drops any unaccepted request; it is the only permitted withdrawal of a pending request. If the same cycle is an accept, `issue_count` still increments. Then `stall` decides: 1 goes to STALL with `fetch_valid` = 0; 0 stays in RUN.
  3. Accept: `issue_count` += 1; `fetch_pc` <= `pc_plus4`. If `stall` = 1, go to STALL and set `fetch_valid` <= 0.
  4. Valid without ready: hold `fetch_pc` and `fetch_valid`. `stall` is ignored, because a pending request is never withdrawn by a stall.
- STALL (`fetch_valid` = 0):
  - Aligned redirect updates `fetch_pc`.
  - Misaligned redirect goes to FAULT.
  - When `stall` = 0 and there is no redirect: go to RUN with `fetch_valid` = 1 and the same `fetch_pc`.
- FAULT:
  - `fetch_valid` = 0 and `fault` = 1.
  - All inputs except `rst` are ignored.
- Arithmetic:
  - Unsigned 32-bit, carry discarded.
  - 32'hFFFF_FFFC + 4 = 32'h0000_0000.
  - `issue_count` wraps from 32'hFFFF_FFFF to 0.

## Timing
- All outputs except `pc_plus4` are registered.
- Latency from `rst` deassertion: `fetch_valid` = 1 one cycle later, with `fetch_pc` = RESET_PC.
- Accept to next request: the new `fetch_pc` is valid the following cycle, giving one request per cycle at full throughput.
- Redirect: new `fetch_pc` is visible the cycle after `redirect_valid`, so there is one cycle of redirect latency.
- Stall release: `fetch_valid` rises one cycle after `stall` falls.
- `fetch_pc` is stable while `fetch_valid & ~fetch_ready`, except when an aligned redirect replaces it.

## Structure
- The shared package `cpu_pkg` holds:
  - state encodings (2-bit: BOOT=0, RUN=1, STALL=2, FAULT=3)
  - `PC_STEP` = 4
  - the default `RESET_PC`
  - the `XLEN` = 32 constant
- Sub-module: one `adder` instance computing `pc_plus4` = `fetch_pc` + `PC_STEP`.
- No other sub-modules: the FSM, PC register and counter live in `pc_fetch`.

## Test plan
- Sequential fetch: release `rst` with `fetch_ready` = 1 and `stall` = 0. Required: `fetch_pc` is 0x0, 0x4, 0x8 on consecutive cycles, and `issue_count` = 3 after three accepts.
- Backpressure: `fetch_ready` = 0 for 3 cycles at `fetch_pc` = 0x8 (with `stall` = 1 during that time). Required: 0x8 and `fetch_valid` = 1 are held, and `issue_count` is unchanged. On ready, the next PC is 0xC.
- Redirect over a pending request: `redirect_pc` = 0x100 while 0x8 is unaccepted. Required: the next cycle shows `fetch_pc` = 0x100, `fetch_valid` = 1, and `issue_count` is unchanged.
- Misaligned redirect: `redirect_pc` = 0x102. Required: the next cycle shows `fault` = 1, `fetch_valid` = 0, `fetch_pc` = 0x102. A later aligned redirect to 0x200 is ignored. `rst` then restores `fetch_pc` = RESET_PC and `fault` = 0.
- Stall on accept: accept at 0x10 with `stall` = 1. Required: the next cycle shows `fetch_valid` = 0 and `fetch_pc` = 0x14. When `stall` falls, the following cycle shows `fetch_valid` = 1 at 0x14.
- Wrap and reset mid-stall:
  - Redirect to 0xFFFF_FFFC, then accept. Required: `fetch_pc` = 0x0.
  - Assert `rst` during STALL. Required: state returns to BOOT and `issue_count` = 0.
